// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the brick-breaker game-flow controller.
package game_sequencer_pkg;

    // Default game parameters
    localparam int unsigned N_BRICKS_DEF     = 10;
    localparam int unsigned LIVES_DEF        = 3;
    localparam int unsigned LIFE_W_DEF       = 2;
    localparam int unsigned LOST_FRAMES_DEF  = 60;
    localparam int unsigned SERVE_FRAMES_DEF = 120;
    localparam int unsigned FCNT_W_DEF       = 8;

    // Fixed interface widths
    localparam int unsigned STATE_W = 3;
    localparam int unsigned IDX_W   = 4;

    // Game phases; the codes are visible on o_state for LEDs and debug
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_LOST     = 3'd3,
        ST_WIN      = 3'd4,
        ST_GAMEOVER = 3'd5
    } state_e;

endpackage

// File: rtl/game_sequencer_start_edge_sync.sv
// Key synchroniser with single-cycle rising-edge event; also used for the DX/SX keys.
module game_sequencer_start_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_evt
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Flops reset to "pressed" so a key already held across reset release gives no event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            o_evt  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_key};
            prev_q <= sync_q[1];
            o_evt  <= sync_q[1] & ~prev_q;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: sequences serve/play/lost/win/game-over and owns bricks and lives.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int unsigned N_BRICKS     = N_BRICKS_DEF,
    parameter int unsigned LIVES        = LIVES_DEF,
    parameter int unsigned LIFE_W       = LIFE_W_DEF,
    parameter int unsigned LOST_FRAMES  = LOST_FRAMES_DEF,
    parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int unsigned FCNT_W       = FCNT_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ani_stb,
    input  logic                i_start,
    input  logic                i_brick_hit,
    input  logic [IDX_W-1:0]    i_brick_idx,
    input  logic                i_ball_lost,
    output logic                o_run,
    output logic                o_serve,
    output logic [N_BRICKS-1:0] o_bricks,
    output logic [LIFE_W-1:0]   o_lives,
    output logic                o_ok,
    output logic                o_ko,
    output logic [STATE_W-1:0]  o_state
);

    state_e              state;
    logic [FCNT_W-1:0]   fcnt;
    logic [FCNT_W-1:0]   fcnt_inc;
    logic                start_evt;
    logic                hit_valid;
    logic [N_BRICKS-1:0] mask_hit;
    logic [LIFE_W-1:0]   lives_dec;

    game_sequencer_start_edge_sync u_start_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key   (i_start),
        .o_evt   (start_evt)
    );

    // Frame counter advanced by one per frame strobe, saturating at all-ones.
    always_comb begin
        fcnt_inc = fcnt;
        if (i_ani_stb && (fcnt != '1)) begin
            fcnt_inc = fcnt + FCNT_W'(1);
        end
    end

    // Brick mask after this cycle's hit (out-of-range index leaves it alone) and decremented lives.
    always_comb begin
        hit_valid = i_brick_hit && (32'(i_brick_idx) < N_BRICKS);
        mask_hit  = o_bricks;
        if (hit_valid) begin
            mask_hit = o_bricks & ~(N_BRICKS'(1) << i_brick_idx);
        end
        lives_dec = o_lives - LIFE_W'(1);
    end

    // Game FSM with registered outputs, brick mask, lives and frame counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            fcnt     <= '0;
            o_run    <= 1'b0;
            o_serve  <= 1'b0;
            o_bricks <= '1;
            o_lives  <= LIFE_W'(LIVES);
            o_ok     <= 1'b0;
            o_ko     <= 1'b0;
        end else begin
            o_serve <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_evt) begin
                        state   <= ST_SERVE;
                        o_serve <= 1'b1;
                        fcnt    <= '0;
                    end
                end
                ST_SERVE: begin
                    fcnt <= fcnt_inc;
                    if (start_evt || (fcnt_inc >= FCNT_W'(SERVE_FRAMES))) begin
                        state <= ST_PLAY;
                        o_run <= 1'b1;
                        fcnt  <= '0;
                    end
                end
                ST_PLAY: begin
                    o_bricks <= mask_hit;
                    // Clearing the last brick outranks a simultaneous ball loss
                    if (mask_hit == '0) begin
                        state <= ST_WIN;
                        o_run <= 1'b0;
                        o_ok  <= 1'b1;
                    end else if (i_ball_lost) begin
                        o_lives <= lives_dec;
                        o_run   <= 1'b0;
                        fcnt    <= '0;
                        if (lives_dec == '0) begin
                            state <= ST_GAMEOVER;
                            o_ko  <= 1'b1;
                        end else begin
                            state <= ST_LOST;
                        end
                    end
                end
                ST_LOST: begin
                    fcnt <= fcnt_inc;
                    if (fcnt_inc >= FCNT_W'(LOST_FRAMES)) begin
                        state   <= ST_SERVE;
                        o_serve <= 1'b1;
                        fcnt    <= '0;
                    end
                end
                ST_WIN, ST_GAMEOVER: begin
                    if (start_evt) begin
                        state    <= ST_SERVE;
                        o_serve  <= 1'b1;
                        o_bricks <= '1;
                        o_lives  <= LIFE_W'(LIVES);
                        o_ok     <= 1'b0;
                        o_ko     <= 1'b0;
                        fcnt     <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    o_run <= 1'b0;
                    o_ok  <= 1'b0;
                    o_ko  <= 1'b0;
                    fcnt  <= '0;
                end
            endcase
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_game_sequencer.sv
// Scenario bench for game_sequencer with a queue of expected output snapshots.
`timescale 1ns/1ps
module tb_game_sequencer;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SERVE    = 3'd1;
    localparam logic [2:0] S_PLAY     = 3'd2;
    localparam logic [2:0] S_LOST     = 3'd3;
    localparam logic [2:0] S_WIN      = 3'd4;
    localparam logic [2:0] S_GAMEOVER = 3'd5;

    typedef struct packed {
        logic [2:0] st;
        logic       run;
        logic       serve;
        logic [9:0] bricks;
        logic [1:0] lives;
        logic       ok;
        logic       ko;
    } snap_t;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b1;
    logic       i_ani_stb = 1'b0;
    logic       i_start = 1'b0;
    logic       i_brick_hit = 1'b0;
    logic [3:0] i_brick_idx = 4'd0;
    logic       i_ball_lost = 1'b0;
    logic       o_run;
    logic       o_serve;
    logic [9:0] o_bricks;
    logic [1:0] o_lives;
    logic       o_ok;
    logic       o_ko;
    logic [2:0] o_state;

    int    errors = 0;
    int    checks = 0;
    snap_t exp_q[$];
    snap_t got;
    snap_t want;
    logic [9:0] exp_b;
    int    idx_list [12];

    game_sequencer dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_ani_stb   (i_ani_stb),
        .i_start     (i_start),
        .i_brick_hit (i_brick_hit),
        .i_brick_idx (i_brick_idx),
        .i_ball_lost (i_ball_lost),
        .o_run       (o_run),
        .o_serve     (o_serve),
        .o_bricks    (o_bricks),
        .o_lives     (o_lives),
        .o_ok        (o_ok),
        .o_ko        (o_ko),
        .o_state     (o_state)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic snap_t sample();
        return '{st: o_state, run: o_run, serve: o_serve, bricks: o_bricks,
                 lives: o_lives, ok: o_ok, ko: o_ko};
    endfunction

    function automatic snap_t mk(input logic [2:0] st, input logic run, input logic serve,
                                 input logic [9:0] b, input logic [1:0] l,
                                 input logic ok, input logic ko);
        return '{st: st, run: run, serve: serve, bricks: b, lives: l, ok: ok, ko: ko};
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("st=%0d run=%b serve=%b bricks=%h lives=%0d ok=%b ko=%b",
                         s.st, s.run, s.serve, s.bricks, s.lives, s.ok, s.ko);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic frame();
        i_ani_stb = 1'b1;
        tick(1);
        i_ani_stb = 1'b0;
        tick(1);
    endtask

    // Press start from SERVE and release; leaves the game in PLAY with the key synchroniser idle.
    task automatic go_play();
        i_start = 1'b1;
        tick(4);
        i_start = 1'b0;
        tick(3);
    endtask

    task automatic test_reset();
        #1 i_rst_n = 1'b0;
        #2;
        exp_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 10'h3FF, 2'd3, 1'b0, 1'b0));
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL reset_vals: got %s want %s", fmt(got), fmt(want)); end
        tick(2);
        i_rst_n = 1'b1;
        exp_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 10'h3FF, 2'd3, 1'b0, 1'b0));
        tick(4);
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL idle_after_release: got %s want %s", fmt(got), fmt(want)); end
    endtask

    task automatic test_start();
        i_start = 1'b1;
        exp_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 10'h3FF, 2'd3, 1'b0, 1'b0));
        exp_q.push_back(mk(S_SERVE, 1'b0, 1'b1, 10'h3FF, 2'd3, 1'b0, 1'b0));
        exp_q.push_back(mk(S_SERVE, 1'b0, 1'b0, 10'h3FF, 2'd3, 1'b0, 1'b0));
        exp_q.push_back(mk(S_SERVE, 1'b0, 1'b0, 10'h3FF, 2'd3, 1'b0, 1'b0));
        tick(3);
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL start_latency_3: got %s want %s", fmt(got), fmt(want)); end
        tick(1);
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL start_serve_pulse: got %s want %s", fmt(got), fmt(want)); end
        tick(1);
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL serve_one_cycle: got %s want %s", fmt(got), fmt(want)); end
        tick(8);
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL held_key_single_evt: got %s want %s", fmt(got), fmt(want)); end
        i_start = 1'b0;
        tick(3);
    endtask

    task automatic test_serve_timeout();
        repeat (119) frame();
        exp_q.push_back(mk(S_SERVE, 1'b0, 1'b0, 10'h3FF, 2'd3, 1'b0, 1'b0));
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL serve_119_frames: got %s want %s", fmt(got), fmt(want)); end
        i_ani_stb = 1'b1;
        exp_q.push_back(mk(S_PLAY, 1'b1, 1'b0, 10'h3FF, 2'd3, 1'b0, 1'b0));
        tick(1);
        i_ani_stb = 1'b0;
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL serve_timeout_play: got %s want %s", fmt(got), fmt(want)); end
    endtask

    task automatic test_bricks();
        logic [2:0] st;
        idx_list = '{0, 1, 2, 3, 3, 12, 4, 5, 6, 7, 8, 9};
        exp_b = 10'h3FF;
        for (int i = 0; i < 12; i++) begin
            i_brick_hit = 1'b1;
            i_brick_idx = 4'(idx_list[i]);
            if (idx_list[i] < 10) exp_b[idx_list[i]] = 1'b0;
            st = (exp_b == 10'h000) ? S_WIN : S_PLAY;
            exp_q.push_back(mk(st, st == S_PLAY, 1'b0, exp_b, 2'd3, st == S_WIN, 1'b0));
            tick(1);
            i_brick_hit = 1'b0;
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL brick_hit[%0d] idx=%0d: got %s want %s", i, idx_list[i], fmt(got), fmt(want));
            end
        end
        // Play events are ignored once the level is won
        i_brick_hit = 1'b1; i_brick_idx = 4'd0; i_ball_lost = 1'b1;
        exp_q.push_back(mk(S_WIN, 1'b0, 1'b0, 10'h000, 2'd3, 1'b1, 1'b0));
        tick(1);
        i_brick_hit = 1'b0; i_ball_lost = 1'b0;
        tick(3);
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL win_ignores_events: got %s want %s", fmt(got), fmt(want)); end
        i_start = 1'b1;
        exp_q.push_back(mk(S_SERVE, 1'b0, 1'b1, 10'h3FF, 2'd3, 1'b0, 1'b0));
        tick(4);
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL restart_from_win: got %s want %s", fmt(got), fmt(want)); end
        i_start = 1'b0;
        tick(3);
    endtask

    task automatic test_lives();
        go_play();
        exp_q.push_back(mk(S_PLAY, 1'b1, 1'b0, 10'h3FF, 2'd3, 1'b0, 1'b0));
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL play_entry_by_key: got %s want %s", fmt(got), fmt(want)); end
        // Hit and loss together: both apply
        i_brick_hit = 1'b1; i_brick_idx = 4'd5; i_ball_lost = 1'b1;
        exp_q.push_back(mk(S_LOST, 1'b0, 1'b0, 10'h3DF, 2'd2, 1'b0, 1'b0));
        tick(1);
        i_brick_hit = 1'b0; i_ball_lost = 1'b0;
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL loss1_with_hit: got %s want %s", fmt(got), fmt(want)); end
        i_ball_lost = 1'b1;
        tick(1);
        i_ball_lost = 1'b0;
        i_start = 1'b1;
        tick(4);
        i_start = 1'b0;
        tick(3);
        exp_q.push_back(mk(S_LOST, 1'b0, 1'b0, 10'h3DF, 2'd2, 1'b0, 1'b0));
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL lost_ignores_key_and_loss: got %s want %s", fmt(got), fmt(want)); end
        repeat (59) frame();
        exp_q.push_back(mk(S_LOST, 1'b0, 1'b0, 10'h3DF, 2'd2, 1'b0, 1'b0));
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL lost_59_frames: got %s want %s", fmt(got), fmt(want)); end
        i_ani_stb = 1'b1;
        exp_q.push_back(mk(S_SERVE, 1'b0, 1'b1, 10'h3DF, 2'd2, 1'b0, 1'b0));
        exp_q.push_back(mk(S_SERVE, 1'b0, 1'b0, 10'h3DF, 2'd2, 1'b0, 1'b0));
        tick(1);
        i_ani_stb = 1'b0;
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL lost_reserve: got %s want %s", fmt(got), fmt(want)); end
        tick(1);
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL reserve_pulse_end: got %s want %s", fmt(got), fmt(want)); end
        go_play();
        i_ball_lost = 1'b1;
        exp_q.push_back(mk(S_LOST, 1'b0, 1'b0, 10'h3DF, 2'd1, 1'b0, 1'b0));
        tick(1);
        i_ball_lost = 1'b0;
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL loss2: got %s want %s", fmt(got), fmt(want)); end
        repeat (59) frame();
        i_ani_stb = 1'b1;
        exp_q.push_back(mk(S_SERVE, 1'b0, 1'b1, 10'h3DF, 2'd1, 1'b0, 1'b0));
        tick(1);
        i_ani_stb = 1'b0;
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL lost2_reserve: got %s want %s", fmt(got), fmt(want)); end
        tick(1);
        go_play();
        i_ball_lost = 1'b1;
        exp_q.push_back(mk(S_GAMEOVER, 1'b0, 1'b0, 10'h3DF, 2'd0, 1'b0, 1'b1));
        exp_q.push_back(mk(S_GAMEOVER, 1'b0, 1'b0, 10'h3DF, 2'd0, 1'b0, 1'b1));
        tick(1);
        i_ball_lost = 1'b0;
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL loss3_gameover: got %s want %s", fmt(got), fmt(want)); end
        repeat (5) frame();
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL gameover_held: got %s want %s", fmt(got), fmt(want)); end
        i_start = 1'b1;
        exp_q.push_back(mk(S_SERVE, 1'b0, 1'b1, 10'h3FF, 2'd3, 1'b0, 1'b0));
        tick(4);
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL restart_from_gameover: got %s want %s", fmt(got), fmt(want)); end
        i_start = 1'b0;
        tick(3);
    endtask

    task automatic test_win_beats_loss();
        go_play();
        for (int i = 1; i < 10; i++) begin
            i_brick_hit = 1'b1;
            i_brick_idx = 4'(i);
            tick(1);
        end
        i_brick_hit = 1'b0;
        exp_q.push_back(mk(S_PLAY, 1'b1, 1'b0, 10'h001, 2'd3, 1'b0, 1'b0));
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL mask_001: got %s want %s", fmt(got), fmt(want)); end
        i_brick_hit = 1'b1; i_brick_idx = 4'd0; i_ball_lost = 1'b1;
        exp_q.push_back(mk(S_WIN, 1'b0, 1'b0, 10'h000, 2'd3, 1'b1, 1'b0));
        tick(1);
        i_brick_hit = 1'b0; i_ball_lost = 1'b0;
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL win_beats_loss: got %s want %s", fmt(got), fmt(want)); end
        i_start = 1'b1;
        tick(4);
        i_start = 1'b0;
        tick(3);
    endtask

    task automatic test_reset_mid_play();
        go_play();
        i_brick_hit = 1'b1; i_brick_idx = 4'd2;
        exp_q.push_back(mk(S_PLAY, 1'b1, 1'b0, 10'h3FB, 2'd3, 1'b0, 1'b0));
        tick(1);
        i_brick_hit = 1'b0;
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL pre_reset_play: got %s want %s", fmt(got), fmt(want)); end
        i_start = 1'b1;
        exp_q.push_back(mk(S_PLAY, 1'b1, 1'b0, 10'h3FB, 2'd3, 1'b0, 1'b0));
        tick(6);
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL play_ignores_key: got %s want %s", fmt(got), fmt(want)); end
        #2 i_rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 10'h3FF, 2'd3, 1'b0, 1'b0));
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL async_reset_immediate: got %s want %s", fmt(got), fmt(want)); end
        tick(2);
        i_rst_n = 1'b1;
        exp_q.push_back(mk(S_IDLE, 1'b0, 1'b0, 10'h3FF, 2'd3, 1'b0, 1'b0));
        tick(8);
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL held_key_no_event: got %s want %s", fmt(got), fmt(want)); end
        i_start = 1'b0;
        tick(3);
        i_start = 1'b1;
        exp_q.push_back(mk(S_SERVE, 1'b0, 1'b1, 10'h3FF, 2'd3, 1'b0, 1'b0));
        tick(4);
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL start_after_release: got %s want %s", fmt(got), fmt(want)); end
        i_start = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_start();
        test_serve_timeout();
        test_bricks();
        test_lives();
        test_win_beats_loss();
        test_reset_mid_play();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
